// File: rtl/board_pkg.sv
// Shared constants and types for the board tile memory arbiter.
//   BOARD_ADDR_W  : board address width, {row[3:0], col[3:0]}
//   TILE_W        : tile code width
//   BOARD_CELLS   : number of board cells
//   WR_FIFO_DEPTH : buffered game-logic write entries
package board_pkg;

  localparam int unsigned BOARD_ADDR_W  = 8;
  localparam int unsigned TILE_W        = 4;
  localparam int unsigned BOARD_CELLS   = 256;
  localparam int unsigned WR_FIFO_DEPTH = 4;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_CLEAR
  } state_e;

  // Owner of the single memory port in a given cycle.
  typedef enum logic [2:0] {
    SLOT_DRAW,
    SLOT_CLR,
    SLOT_WR,
    SLOT_RD,
    SLOT_NONE
  } slot_e;

endpackage

// File: rtl/board_wr_fifo.sv
// Write buffer for game-logic tile writes: a synchronous FIFO of {addr, data}.
// Ports:
//   clk_i, rst_i                  : clock, asynchronous active-high reset
//   push_i, push_addr_i/data_i    : push request (ignored while full)
//   pop_i                         : pop request (ignored while empty)
//   head_addr_o, head_data_o      : entry at the head of the queue
//   full_o, empty_o               : status from the registered entry count
module board_wr_fifo #(
  parameter int unsigned AddrWidth = 8,
  parameter int unsigned DataWidth = 4,
  parameter int unsigned Depth     = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic [AddrWidth-1:0] push_addr_i,
  input  logic [DataWidth-1:0] push_data_i,
  input  logic                 pop_i,
  output logic [AddrWidth-1:0] head_addr_o,
  output logic [DataWidth-1:0] head_data_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned PtrW   = $clog2(Depth);
  localparam int unsigned EntryW = AddrWidth + DataWidth;
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(Depth);

  logic [EntryW-1:0] mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]     cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign full_o  = (cnt_q == DepthCnt);
  assign empty_o = (cnt_q == '0);
  // A full FIFO refuses a push even when a pop frees a slot the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign {head_addr_o, head_data_o} = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= {push_addr_i, push_data_i};
  end

endmodule

// File: rtl/board_mem_arbiter.sv
// Board tile memory (16x16 cells of 4-bit tile codes) with a single port shared by
// the board drawer, buffered game-logic writes, game-logic reads and a clear sequencer.
// Port priority per cycle: draw > clear > write-buffer drain > read.
// Ports:
//   i_pclk, i_rst                          : pixel clock, async active-high reset
//   i_draw_en, i_draw_addr, o_draw_data    : drawer read, data 1 cycle later
//   i_wr_valid/addr/data, o_wr_ready       : buffered write, valid/ready handshake
//   i_rd_valid, i_rd_addr, o_rd_ready      : read request and grant pulse
//   o_rd_data, o_rd_dvalid                 : read result, 1 cycle after grant
//   i_clr_start, i_clr_value, o_clr_busy   : whole-board fill
module board_mem_arbiter
  import board_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = BOARD_ADDR_W,
  parameter int unsigned DATA_WIDTH = TILE_W,
  parameter int unsigned FIFO_DEPTH = WR_FIFO_DEPTH
) (
  input  logic                  i_pclk,
  input  logic                  i_rst,
  input  logic                  i_draw_en,
  input  logic [ADDR_WIDTH-1:0] i_draw_addr,
  output logic [DATA_WIDTH-1:0] o_draw_data,
  input  logic                  i_wr_valid,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_wr_ready,
  input  logic                  i_rd_valid,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic                  o_rd_ready,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_dvalid,
  input  logic                  i_clr_start,
  input  logic [DATA_WIDTH-1:0] i_clr_value,
  output logic                  o_clr_busy
);

  localparam int unsigned Cells = 2 ** ADDR_WIDTH;

  state_e                state_q, state_d;
  slot_e                 slot;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_WIDTH-1:0] clr_val_q, clr_val_d;

  logic                  fifo_full, fifo_empty;
  logic [ADDR_WIDTH-1:0] fifo_addr;
  logic [DATA_WIDTH-1:0] fifo_data;

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] mem [Cells];

  logic [DATA_WIDTH-1:0] draw_data_q, rd_data_q;
  logic                  rd_dvalid_q;

  board_wr_fifo #(
    .AddrWidth(ADDR_WIDTH),
    .DataWidth(DATA_WIDTH),
    .Depth    (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk_i      (i_pclk),
    .rst_i      (i_rst),
    .push_i     (i_wr_valid),
    .push_addr_i(i_wr_addr),
    .push_data_i(i_wr_data),
    .pop_i      (slot == SLOT_WR),
    .head_addr_o(fifo_addr),
    .head_data_o(fifo_data),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // Reads wait for an empty buffer so they always see every accepted write.
  always_comb begin
    slot = SLOT_NONE;
    if (i_draw_en)                slot = SLOT_DRAW;
    else if (state_q == ST_CLEAR) slot = SLOT_CLR;
    else if (!fifo_empty)         slot = SLOT_WR;
    else if (i_rd_valid)          slot = SLOT_RD;
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = i_rd_addr;
    ram_wdata = fifo_data;
    unique case (slot)
      SLOT_DRAW: ram_addr = i_draw_addr;
      SLOT_CLR: begin
        ram_we    = 1'b1;
        ram_addr  = clr_cnt_q;
        ram_wdata = clr_val_q;
      end
      SLOT_WR: begin
        ram_we   = 1'b1;
        ram_addr = fifo_addr;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_val_d = clr_val_q;
    case (state_q)
      ST_IDLE: begin
        if (i_clr_start) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
          clr_val_d = i_clr_value;
        end
      end
      ST_CLEAR: begin
        // Clear only advances on cycles the drawer leaves free.
        if (slot == SLOT_CLR) begin
          clr_cnt_d = clr_cnt_q + 1'b1;
          if (&clr_cnt_q) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_pclk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      clr_cnt_q   <= '0;
      clr_val_q   <= '0;
      draw_data_q <= '0;
      rd_data_q   <= '0;
      rd_dvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      clr_val_q   <= clr_val_d;
      rd_dvalid_q <= (slot == SLOT_RD);
      if (slot == SLOT_DRAW) draw_data_q <= mem[ram_addr];
      if (slot == SLOT_RD)   rd_data_q   <= mem[ram_addr];
    end
  end

  // Board contents survive reset.
  always_ff @(posedge i_pclk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  assign o_draw_data = draw_data_q;
  assign o_rd_data   = rd_data_q;
  assign o_rd_dvalid = rd_dvalid_q;
  assign o_rd_ready  = (slot == SLOT_RD);
  assign o_wr_ready  = !fifo_full;
  assign o_clr_busy  = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Self-checking bench for board_mem_arbiter: directed scenarios plus a randomized
// run, all checked against a queue/array model of the board.
module tb_board_mem_arbiter;

  logic       i_pclk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_draw_en = 1'b0;
  logic [7:0] i_draw_addr = '0;
  logic [3:0] o_draw_data;
  logic       i_wr_valid = 1'b0;
  logic [7:0] i_wr_addr = '0;
  logic [3:0] i_wr_data = '0;
  logic       o_wr_ready;
  logic       i_rd_valid = 1'b0;
  logic [7:0] i_rd_addr = '0;
  logic       o_rd_ready;
  logic [3:0] o_rd_data;
  logic       o_rd_dvalid;
  logic       i_clr_start = 1'b0;
  logic [3:0] i_clr_value = '0;
  logic       o_clr_busy;

  board_mem_arbiter dut (
    .i_pclk     (i_pclk),
    .i_rst      (i_rst),
    .i_draw_en  (i_draw_en),
    .i_draw_addr(i_draw_addr),
    .o_draw_data(o_draw_data),
    .i_wr_valid (i_wr_valid),
    .i_wr_addr  (i_wr_addr),
    .i_wr_data  (i_wr_data),
    .o_wr_ready (o_wr_ready),
    .i_rd_valid (i_rd_valid),
    .i_rd_addr  (i_rd_addr),
    .o_rd_ready (o_rd_ready),
    .o_rd_data  (o_rd_data),
    .o_rd_dvalid(o_rd_dvalid),
    .i_clr_start(i_clr_start),
    .i_clr_value(i_clr_value),
    .o_clr_busy (o_clr_busy)
  );

  always #5 i_pclk = ~i_pclk;

  typedef struct packed {
    logic [7:0] addr;
    logic [3:0] data;
  } wr_t;

  // Reference model of the board and its pending work.
  logic [3:0] m_mem [256];
  wr_t        m_q [$];
  bit         m_clr;
  int         m_idx;
  logic [3:0] m_cval, m_draw, m_rd;
  bit         m_dv;

  logic       s_wr_ready, s_rd_ready;  // DUT handshake outputs seen before the edge
  logic       e_wr_ready, e_rd_ready;  // model expectation for the same cycle
  logic [3:0] got [256];
  int         checks = 0;
  int         errors = 0;

  task automatic model_reset();
    m_q.delete();
    m_clr  = 1'b0;
    m_idx  = 0;
    m_draw = '0;
    m_rd   = '0;
    m_dv   = 1'b0;
  endtask

  // One clock cycle: sample handshakes at the falling edge, advance the model at the
  // rising edge, return 1 time unit later.
  task automatic tick();
    bit  was_clr;
    wr_t w;
    @(negedge i_pclk);
    s_wr_ready = o_wr_ready;
    s_rd_ready = o_rd_ready;
    e_wr_ready = (m_q.size() < 4);
    e_rd_ready = i_rd_valid && !i_draw_en && !m_clr && (m_q.size() == 0);
    @(posedge i_pclk);
    was_clr = m_clr;
    m_dv    = 1'b0;
    if (i_draw_en) begin
      m_draw = m_mem[i_draw_addr];
    end else if (m_clr) begin
      m_mem[m_idx[7:0]] = m_cval;
      m_idx++;
      if (m_idx == 256) m_clr = 1'b0;
    end else if (m_q.size() != 0) begin
      w = m_q.pop_front();
      m_mem[w.addr] = w.data;
    end else if (i_rd_valid) begin
      m_rd = m_mem[i_rd_addr];
      m_dv = 1'b1;
    end
    if (i_wr_valid && e_wr_ready) begin
      w.addr = i_wr_addr;
      w.data = i_wr_data;
      m_q.push_back(w);
    end
    if (!was_clr && i_clr_start) begin
      m_clr  = 1'b1;
      m_idx  = 0;
      m_cval = i_clr_value;
    end
    #1;
  endtask

  // Caller raises i_rst; this holds it for two edges and releases it mid-cycle.
  task automatic hold_reset();
    model_reset();
    repeat (2) @(posedge i_pclk);
    @(negedge i_pclk);
    i_draw_en   = 1'b0;
    i_wr_valid  = 1'b0;
    i_rd_valid  = 1'b0;
    i_clr_start = 1'b0;
    i_rst       = 1'b0;
    @(posedge i_pclk);
    #1;
  endtask

  task automatic draw_sweep();
    i_draw_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      i_draw_addr = 8'(i);
      tick();
      got[i] = o_draw_data;
    end
    i_draw_en = 1'b0;
  endtask

  task automatic run_clear(input logic [3:0] val);
    int n = 0;
    i_clr_value = val;
    i_clr_start = 1'b1;
    tick();
    i_clr_start = 1'b0;
    while (m_clr && n < 600) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    hold_reset();
    checks += 6;
    if (o_wr_ready !== 1'b1) begin errors++; $display("FAIL rst_wr_ready got %b want 1", o_wr_ready); end
    if (o_rd_ready !== 1'b0) begin errors++; $display("FAIL rst_rd_ready got %b want 0", o_rd_ready); end
    if (o_rd_dvalid !== 1'b0) begin errors++; $display("FAIL rst_dvalid got %b want 0", o_rd_dvalid); end
    if (o_clr_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", o_clr_busy); end
    if (o_draw_data !== 4'h0) begin errors++; $display("FAIL rst_draw_data got %h want 0", o_draw_data); end
    if (o_rd_data !== 4'h0) begin errors++; $display("FAIL rst_rd_data got %h want 0", o_rd_data); end
    run_clear(4'h0);
    checks++;
    if (o_clr_busy !== 1'b0) begin errors++; $display("FAIL init_clear busy got %b want 0", o_clr_busy); end
    // Fill the buffer behind the drawer and start a clear that cannot progress.
    i_draw_en   = 1'b1;
    i_clr_value = 4'hE;
    i_clr_start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_wr_valid = 1'b1;
      i_wr_addr  = 8'h70 + 8'(k);
      i_wr_data  = 4'hF;
      tick();
      i_clr_start = 1'b0;
    end
    i_wr_addr = 8'h74;
    checks += 2;
    if (o_wr_ready !== 1'b0) begin errors++; $display("FAIL full_wr_ready got %b want 0", o_wr_ready); end
    if (o_clr_busy !== 1'b1) begin errors++; $display("FAIL pre_rst_busy got %b want 1", o_clr_busy); end
    #4;
    i_rst = 1'b1;
    #1;
    checks += 3;
    if (o_wr_ready !== 1'b1) begin errors++; $display("FAIL async_rst_wr_ready got %b want 1", o_wr_ready); end
    if (o_clr_busy !== 1'b0) begin errors++; $display("FAIL async_rst_busy got %b want 0", o_clr_busy); end
    if (o_rd_dvalid !== 1'b0) begin errors++; $display("FAIL async_rst_dvalid got %b want 0", o_rd_dvalid); end
    hold_reset();
    draw_sweep();
    for (int i = 0; i < 256; i++) begin
      checks++;
      if (got[i] !== 4'h0) begin errors++; $display("FAIL rst_lost_write addr %0h got %h want 0", i, got[i]); end
    end
  endtask

  task automatic test_write_read();
    i_draw_en  = 1'b0;
    i_wr_valid = 1'b1;
    i_wr_addr  = 8'h35;
    i_wr_data  = 4'h9;
    tick();
    i_wr_valid = 1'b0;
    i_rd_valid = 1'b1;
    i_rd_addr  = 8'h35;
    checks++;
    if (s_wr_ready !== 1'b1) begin errors++; $display("FAIL wr_accept got %b want 1", s_wr_ready); end
    tick();
    checks++;
    if (s_rd_ready !== 1'b0) begin errors++; $display("FAIL rd_stall_drain got %b want 0", s_rd_ready); end
    tick();
    i_rd_valid = 1'b0;
    checks += 3;
    if (s_rd_ready !== 1'b1) begin errors++; $display("FAIL rd_grant got %b want 1", s_rd_ready); end
    if (o_rd_dvalid !== 1'b1) begin errors++; $display("FAIL rd_dvalid got %b want 1", o_rd_dvalid); end
    if (o_rd_data !== 4'h9) begin errors++; $display("FAIL rd_data got %h want 9", o_rd_data); end
    tick();
    checks += 2;
    if (o_rd_dvalid !== 1'b0) begin errors++; $display("FAIL rd_dvalid_pulse got %b want 0", o_rd_dvalid); end
    if (o_rd_data !== 4'h9) begin errors++; $display("FAIL rd_data_hold got %h want 9", o_rd_data); end
  endtask

  task automatic test_draw_priority();
    logic [7:0] wa [5] = '{8'h40, 8'h41, 8'h40, 8'h42, 8'h43};
    logic [3:0] wd [5] = '{4'h1, 4'h2, 4'h7, 4'h4, 4'h5};
    i_wr_valid = 1'b1;
    i_wr_addr  = 8'h00;
    i_wr_data  = 4'h3;
    tick();
    i_wr_valid = 1'b0;
    tick();
    i_draw_en   = 1'b1;
    i_draw_addr = 8'h00;
    for (int k = 0; k < 20; k++) begin
      i_wr_valid = (k < 5);
      if (k < 5) begin
        i_wr_addr = wa[k];
        i_wr_data = wd[k];
      end
      if (k == 1) i_draw_addr = 8'h40;
      else if (k > 1) i_draw_addr = 8'($urandom);
      tick();
      checks++;
      if (k == 0) begin
        if (o_draw_data !== 4'h3) begin errors++; $display("FAIL draw_preload got %h want 3", o_draw_data); end
      end else if (k == 1) begin
        if (o_draw_data !== 4'h0) begin errors++; $display("FAIL draw_no_write got %h want 0", o_draw_data); end
      end else if (o_draw_data !== m_draw) begin
        errors++; $display("FAIL draw_data cyc %0d got %h want %h", k, o_draw_data, m_draw);
      end
      if (k < 5) begin
        checks++;
        if (s_wr_ready !== (k < 4)) begin errors++; $display("FAIL draw_wr_ready cyc %0d got %b want %b", k, s_wr_ready, k < 4); end
      end
    end
    i_wr_valid = 1'b0;
    i_draw_en  = 1'b0;
    i_rd_valid = 1'b1;
    i_rd_addr  = 8'h40;
    for (int k = 0; k < 5; k++) begin
      i_wr_valid = 1'b1;  // write offered during drain is only taken once no longer full
      i_wr_addr  = 8'h44;
      i_wr_data  = 4'h6;
      if (k > 0) i_wr_valid = 1'b0;
      tick();
      checks += 2;
      if (s_wr_ready !== (k != 0)) begin errors++; $display("FAIL drain_wr_ready cyc %0d got %b want %b", k, s_wr_ready, k != 0); end
      if (s_rd_ready !== (k == 4)) begin errors++; $display("FAIL drain_rd_ready cyc %0d got %b want %b", k, s_rd_ready, k == 4); end
    end
    i_rd_valid = 1'b0;
    checks += 2;
    if (o_rd_dvalid !== 1'b1) begin errors++; $display("FAIL drain_dvalid got %b want 1", o_rd_dvalid); end
    if (o_rd_data !== 4'h7) begin errors++; $display("FAIL drain_order got %h want 7", o_rd_data); end
    draw_sweep();
    checks += 5;
    if (got[8'h40] !== 4'h7) begin errors++; $display("FAIL cell40 got %h want 7", got[8'h40]); end
    if (got[8'h41] !== 4'h2) begin errors++; $display("FAIL cell41 got %h want 2", got[8'h41]); end
    if (got[8'h42] !== 4'h4) begin errors++; $display("FAIL cell42 got %h want 4", got[8'h42]); end
    if (got[8'h43] !== 4'h0) begin errors++; $display("FAIL cell43 got %h want 0", got[8'h43]); end
    if (got[8'h44] !== 4'h0) begin errors++; $display("FAIL cell44 got %h want 0", got[8'h44]); end
  endtask

  task automatic test_clear();
    int n = 0;
    i_clr_value = 4'hA;
    i_clr_start = 1'b1;
    tick();
    i_clr_start = 1'b0;
    while (o_clr_busy === 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 256) begin errors++; $display("FAIL clear_busy_len got %0d want 256", n); end
    draw_sweep();
    for (int i = 0; i < 256; i++) begin
      checks++;
      if (got[i] !== 4'hA) begin errors++; $display("FAIL clear_cell %0h got %h want a", i, got[i]); end
    end
    for (int k = 0; k < 3; k++) begin
      i_wr_valid = 1'b1;
      i_wr_addr  = 8'($urandom);
      i_wr_data  = 4'h1 + 4'(k);
      tick();
    end
    i_wr_valid = 1'b0;
    repeat (3) tick();
    i_clr_start = 1'b1;
    tick();
    i_clr_start = 1'b0;
    n = 0;
    while (o_clr_busy === 1'b1 && n < 2000) begin
      i_draw_en   = (n % 2 == 0);
      i_draw_addr = 8'($urandom);
      tick();
      if (i_draw_en) begin
        checks++;
        if (o_draw_data !== m_draw) begin errors++; $display("FAIL clear_draw cyc %0d got %h want %h", n, o_draw_data, m_draw); end
      end
      n++;
    end
    i_draw_en = 1'b0;
    checks++;
    if (n !== 512) begin errors++; $display("FAIL clear_toggle_len got %0d want 512", n); end
    draw_sweep();
    for (int i = 0; i < 256; i++) begin
      checks++;
      if (got[i] !== 4'hA) begin errors++; $display("FAIL clear_toggle_cell %0h got %h want a", i, got[i]); end
    end
  endtask

  task automatic test_clear_fifo();
    int n = 0;
    bit granted = 1'b0;
    i_wr_valid = 1'b1;
    i_wr_addr  = 8'h20;
    i_wr_data  = 4'h5;
    tick();
    i_wr_valid = 1'b0;
    tick();
    i_clr_value = 4'hA;
    i_clr_start = 1'b1;
    tick();
    i_clr_start = 1'b0;
    i_wr_valid  = 1'b1;
    i_wr_addr   = 8'h10;
    i_wr_data   = 4'h2;
    tick();
    i_wr_valid = 1'b0;
    checks++;
    if (s_wr_ready !== 1'b1) begin errors++; $display("FAIL clr_fifo_accept got %b want 1", s_wr_ready); end
    i_rd_valid = 1'b1;
    i_rd_addr  = 8'h10;
    while (!granted && n < 600) begin
      tick();
      n++;
      checks += 2;
      if (s_rd_ready !== e_rd_ready) begin errors++; $display("FAIL clr_fifo_rd_ready cyc %0d got %b want %b", n, s_rd_ready, e_rd_ready); end
      if (o_clr_busy !== m_clr) begin errors++; $display("FAIL clr_fifo_busy cyc %0d got %b want %b", n, o_clr_busy, m_clr); end
      granted = (s_rd_ready === 1'b1);
    end
    i_rd_valid = 1'b0;
    checks += 3;
    if (n !== 257) begin errors++; $display("FAIL clr_fifo_stall got %0d want 257", n); end
    if (o_rd_dvalid !== 1'b1) begin errors++; $display("FAIL clr_fifo_dvalid got %b want 1", o_rd_dvalid); end
    if (o_rd_data !== 4'h2) begin errors++; $display("FAIL clr_fifo_rd_data got %h want 2", o_rd_data); end
    draw_sweep();
    for (int i = 0; i < 256; i++) begin
      checks++;
      if (got[i] !== ((i == 16) ? 4'h2 : 4'hA)) begin
        errors++; $display("FAIL clr_fifo_cell %0h got %h want %h", i, got[i], (i == 16) ? 4'h2 : 4'hA);
      end
    end
  endtask

  task automatic test_reset_midclear();
    int n = 0;
    run_clear(4'h3);
    i_clr_value = 4'h9;
    i_clr_start = 1'b1;
    tick();
    i_clr_start = 1'b0;
    while (m_idx < 100 && n < 300) begin
      tick();
      n++;
    end
    #4;
    i_rst = 1'b1;
    #1;
    checks++;
    if (o_clr_busy !== 1'b0) begin errors++; $display("FAIL midclr_busy got %b want 0", o_clr_busy); end
    hold_reset();
    draw_sweep();
    for (int i = 0; i < 256; i++) begin
      checks++;
      if (got[i] !== ((i < 100) ? 4'h9 : 4'h3)) begin
        errors++; $display("FAIL midclr_cell %0h got %h want %h", i, got[i], (i < 100) ? 4'h9 : 4'h3);
      end
    end
  endtask

  task automatic test_random();
    int n = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      i_draw_en   = ($urandom_range(0, 2) == 0);
      i_draw_addr = 8'h50 + 8'($urandom_range(0, 7));
      if (!i_rd_valid && $urandom_range(0, 3) == 0) begin
        i_rd_valid = 1'b1;
        i_rd_addr  = 8'h50 + 8'($urandom_range(0, 7));
      end
      i_clr_start = (cyc == 100) || ($urandom_range(0, 299) == 0);
      i_clr_value = 4'($urandom);
      tick();
      checks += 5;
      if (s_wr_ready !== e_wr_ready) begin errors++; $display("FAIL rnd_wr_ready cyc %0d got %b want %b", cyc, s_wr_ready, e_wr_ready); end
      if (s_rd_ready !== e_rd_ready) begin errors++; $display("FAIL rnd_rd_ready cyc %0d got %b want %b", cyc, s_rd_ready, e_rd_ready); end
      if (o_draw_data !== m_draw) begin errors++; $display("FAIL rnd_draw cyc %0d got %h want %h", cyc, o_draw_data, m_draw); end
      if (o_rd_dvalid !== m_dv) begin errors++; $display("FAIL rnd_dvalid cyc %0d got %b want %b", cyc, o_rd_dvalid, m_dv); end
      if (o_clr_busy !== m_clr) begin errors++; $display("FAIL rnd_busy cyc %0d got %b want %b", cyc, o_clr_busy, m_clr); end
      if (m_dv) begin
        checks++;
        if (o_rd_data !== m_rd) begin errors++; $display("FAIL rnd_rd_data cyc %0d got %h want %h", cyc, o_rd_data, m_rd); end
      end
      if (s_rd_ready === 1'b1) i_rd_valid = 1'b0;
      if (!i_wr_valid || s_wr_ready === 1'b1) begin
        i_wr_valid = ($urandom_range(0, 2) != 0);
        i_wr_addr  = 8'h50 + 8'($urandom_range(0, 7));
        i_wr_data  = 4'($urandom);
      end
    end
    i_draw_en   = 1'b0;
    i_wr_valid  = 1'b0;
    i_rd_valid  = 1'b0;
    i_clr_start = 1'b0;
    while ((m_clr || m_q.size() != 0) && n < 600) begin
      tick();
      n++;
    end
    draw_sweep();
    for (int i = 0; i < 256; i++) begin
      checks++;
      if (got[i] !== m_mem[i]) begin errors++; $display("FAIL rnd_cell %0h got %h want %h", i, got[i], m_mem[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_draw_priority();
    test_clear();
    test_clear_fifo();
    test_reset_midclear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
